// File: rtl/regdump_pkg.sv
// rtl/regdump_pkg.sv - shared encodings and constants for the register dump streamer
package regdump_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ADDR = 2'd1,
    S_SEND = 2'd2,
    S_DONE = 2'd3
  } dumpState_t;

  localparam int         BYTES_PER_REG   = 4;
  localparam int         MAX_BYTES       = BYTES_PER_REG + 1;
  localparam logic [2:0] IDX_BYTE_PREFIX = 3'b000;

  // Left-aligned snapshot: the first byte to send always sits in the top byte lane.
  function automatic logic [8*MAX_BYTES-1:0] packSnap(
    input logic [4:0]  idx,
    input logic [31:0] content,
    input bit          emitIndex
  );
    if (emitIndex)
      return {IDX_BYTE_PREFIX, idx, content};
    else
      return {content, 8'h00};
  endfunction

endpackage

// File: rtl/regdump_word_byte_serializer.sv
// rtl/regdump_word_byte_serializer.sv - holds up to five bytes and hands them out MSB-first
module word_byte_serializer
  import regdump_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   load,
  input  logic [8*MAX_BYTES-1:0] loadBytes,
  input  logic [2:0]             loadCount,
  input  logic                   clear,
  output logic [7:0]             outData,
  output logic                   outValid,
  input  logic                   outReady,
  output logic                   lastAccept
);

  logic [8*MAX_BYTES-1:0] shiftReg;
  logic [2:0]             remaining;
  logic                   accept;

  assign accept     = outValid & outReady;
  assign outData    = shiftReg[8*MAX_BYTES-1 -: 8];
  assign lastAccept = accept && (remaining == 3'd1);

  // Data comes straight from the shift register, so it cannot move while a byte is unaccepted.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      shiftReg  <= '0;
      remaining <= '0;
      outValid  <= 1'b0;
    end else if (clear) begin
      remaining <= '0;
      outValid  <= 1'b0;
    end else if (load) begin
      shiftReg  <= loadBytes;
      remaining <= loadCount;
      outValid  <= (loadCount != 3'd0);
    end else if (accept) begin
      shiftReg  <= {shiftReg[8*MAX_BYTES-9:0], 8'h00};
      remaining <= remaining - 3'd1;
      if (remaining == 3'd1)
        outValid <= 1'b0;
    end
  end

endmodule

// File: rtl/regdump_streamer.sv
// rtl/regdump_streamer.sv - walks the register file debug port and streams each register as bytes
module regdump_streamer
  import regdump_pkg::*;
#(
  parameter int unsigned FIRST_REG  = 0,
  parameter int unsigned LAST_REG   = 31,
  parameter bit          EMIT_INDEX = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        abort,
  output logic [4:0]  dbgReg,
  input  logic [31:0] dbgContent,
  output logic [7:0]  out_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        busy,
  output logic        done
);

  localparam logic [4:0] FIRST_IDX  = 5'(FIRST_REG);
  localparam logic [4:0] LAST_IDX   = 5'(LAST_REG);
  localparam logic [2:0] SNAP_COUNT = EMIT_INDEX ? 3'(BYTES_PER_REG + 1) : 3'(BYTES_PER_REG);

  dumpState_t state, stateNext;
  logic [4:0] idx, idxNext;
  logic       serLoad, serClear, serLast;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= S_IDLE;
      idx   <= FIRST_IDX;
    end else begin
      state <= stateNext;
      idx   <= idxNext;
    end
  end

  // Abort outranks everything once a dump is running; the serializer is flushed with it.
  always_comb begin
    stateNext = state;
    idxNext   = idx;
    serLoad   = 1'b0;
    serClear  = 1'b0;
    if (state != S_IDLE && abort) begin
      stateNext = S_IDLE;
      serClear  = 1'b1;
    end else begin
      case (state)
        S_IDLE: begin
          if (start && !abort) begin
            stateNext = S_ADDR;
            idxNext   = FIRST_IDX;
          end
        end
        S_ADDR: begin
          serLoad   = 1'b1;
          stateNext = S_SEND;
        end
        S_SEND: begin
          if (serLast) begin
            if (idx == LAST_IDX) begin
              stateNext = S_DONE;
            end else begin
              idxNext   = idx + 5'd1;
              stateNext = S_ADDR;
            end
          end
        end
        S_DONE:  stateNext = S_IDLE;
        default: stateNext = S_IDLE;
      endcase
    end
  end

  assign dbgReg = idx;
  assign busy   = (state != S_IDLE);
  assign done   = (state == S_DONE);

  word_byte_serializer uSer (
    .clk        (clk),
    .rst        (rst),
    .load       (serLoad),
    .loadBytes  (packSnap(idx, dbgContent, EMIT_INDEX)),
    .loadCount  (SNAP_COUNT),
    .clear      (serClear),
    .outData    (out_data),
    .outValid   (out_valid),
    .outReady   (out_ready),
    .lastAccept (serLast)
  );

endmodule

// File: tb/tb_regdump_streamer.sv
// tb/tb_regdump_streamer.sv - directed bench for regdump_streamer
module tb_regdump_streamer;

  logic        clk = 1'b0;
  logic        rst, start, abort, outReady;
  logic [4:0]  dbgReg;
  logic [31:0] dbgContent;
  logic [7:0]  outData;
  logic        outValid, busy, done;

  logic        start2, ready2;
  logic [4:0]  dbgReg2;
  logic [31:0] dbgContent2;
  logic [7:0]  outData2;
  logic        outValid2, busy2, done2;

  logic [31:0] regs [32];
  logic [31:0] snap [32];
  logic [7:0]  q [$];
  logic [7:0]  q2 [$];

  int nTests = 0;
  int nFail  = 0;

  always #5 clk = ~clk;

  assign dbgContent  = regs[dbgReg];
  assign dbgContent2 = (dbgReg2 == 5'd31) ? 32'h1234_5678 : 32'h0;

  regdump_streamer #(.FIRST_REG(0), .LAST_REG(31), .EMIT_INDEX(1'b1)) uDut (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
    .dbgReg(dbgReg), .dbgContent(dbgContent),
    .out_data(outData), .out_valid(outValid), .out_ready(outReady),
    .busy(busy), .done(done)
  );

  regdump_streamer #(.FIRST_REG(31), .LAST_REG(31), .EMIT_INDEX(1'b0)) uDut2 (
    .clk(clk), .rst(rst), .start(start2), .abort(1'b0),
    .dbgReg(dbgReg2), .dbgContent(dbgContent2),
    .out_data(outData2), .out_valid(outValid2), .out_ready(ready2),
    .busy(busy2), .done(done2)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    nTests++;
    if (obs !== exp) begin
      nFail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic int countMismatch();
    int bad = 0;
    for (int k = 0; k < q.size(); k++) begin
      int i = k / 5;
      int p = k % 5;
      logic [7:0] e;
      e = (p == 0) ? 8'(i) : snap[i][8*(4-p) +: 8];
      if (i > 31 || q[k] !== e) bad++;
    end
    return bad;
  endfunction

  function automatic logic [31:0] wordOf(input int i);
    if (q.size() < 5*i + 5) return 32'hxxxx_xxxx;
    return {q[5*i+1], q[5*i+2], q[5*i+3], q[5*i+4]};
  endfunction

  // Cycle numbering: the cycle after the edge that samples start is cycle 1.
  task automatic runDump(input int readyMode, input bit doSnap,
                         output int doneCycle, output int doneCount,
                         output int stableErrs, output int firstValid,
                         output logic [4:0] regAtCycle1);
    int c;
    bit holdAct, wrPending, sawAddr7;
    logic [7:0] holdData;
    q.delete();
    for (int i = 0; i < 32; i++) snap[i] = regs[i];
    doneCycle = -1; doneCount = 0; stableErrs = 0; firstValid = -1;
    holdAct = 0; wrPending = 0; sawAddr7 = 0; holdData = '0; regAtCycle1 = 'x;
    start = 1'b1;
    step();
    start = 1'b0;
    c = 1;
    while (c < 3000) begin
      if (wrPending) begin
        regs[7] = 32'hDEAD_BEEF;
        wrPending = 0;
      end
      if (doSnap && !sawAddr7 && busy && !outValid && dbgReg == 5'd7) begin
        sawAddr7 = 1;
        wrPending = 1;
      end
      if (c == 1) regAtCycle1 = dbgReg;
      outReady = (readyMode == 0) ? 1'b1 : (c % 3 == 0);
      if (holdAct && outValid && outData !== holdData) stableErrs++;
      holdAct  = outValid && !outReady;
      holdData = outData;
      if (outValid && outReady) q.push_back(outData);
      if (outValid && firstValid < 0) firstValid = c;
      if (done) begin
        doneCount++;
        if (doneCycle < 0) doneCycle = c;
      end
      if (!busy && c > 1) break;
      step();
      c++;
    end
    outReady = 1'b1;
  endtask

  initial begin
    int dc, dn, se, fv, acc, seen;
    bit hit;
    logic [4:0] r1;

    for (int i = 0; i < 32; i++) regs[i] = 32'h0101_0101 * i;
    rst = 1'b0; start = 1'b0; abort = 1'b0; outReady = 1'b1;
    start2 = 1'b0; ready2 = 1'b1;
    step(); step();
    check("rst_valid", 64'(outValid), 64'd0);
    check("rst_busy",  64'(busy),     64'd0);
    check("rst_done",  64'(done),     64'd0);
    check("rst_reg",   64'(dbgReg),   64'd0);
    check("rst_data",  64'(outData),  64'd0);
    check("rst_reg2",  64'(dbgReg2),  64'd31);
    rst = 1'b1;
    step();

    runDump(0, 0, dc, dn, se, fv, r1);
    check("d1_bytes",     64'(q.size()),        64'd160);
    check("d1_data",      64'(countMismatch()), 64'd0);
    check("d1_reg5",      64'({q[25], q[26], q[27], q[28], q[29]}), 64'h05_0505_0505);
    check("d1_done_cnt",  64'(dn), 64'd1);
    check("d1_done_cyc",  64'(dc), 64'd193);
    check("d1_first_val", 64'(fv), 64'd2);
    check("d1_reg_cyc1",  64'(r1), 64'd0);

    runDump(1, 0, dc, dn, se, fv, r1);
    check("bp_bytes",    64'(q.size()),        64'd160);
    check("bp_data",     64'(countMismatch()), 64'd0);
    check("bp_stable",   64'(se), 64'd0);
    check("bp_done_cnt", 64'(dn), 64'd1);

    runDump(0, 1, dc, dn, se, fv, r1);
    check("snap_old",      64'(wordOf(7)),       64'h0707_0707);
    check("snap_data",     64'(countMismatch()), 64'd0);
    check("snap_regfile",  64'(regs[7]),         64'hDEAD_BEEF);
    runDump(0, 0, dc, dn, se, fv, r1);
    check("snap_new",      64'(wordOf(7)),       64'hDEAD_BEEF);
    check("snap_new_data", 64'(countMismatch()), 64'd0);
    regs[7] = 32'h0707_0707;

    start = 1'b1; step(); start = 1'b0;
    acc = 0; hit = 0;
    for (int c = 0; c < 200; c++) begin
      if (acc == 12 && outValid) begin
        hit = 1;
        break;
      end
      if (outValid && outReady) acc++;
      step();
    end
    check("abort_reached", 64'(hit), 64'd1);
    check("abort_reg",     64'(dbgReg), 64'd2);
    outReady = 1'b0;
    abort = 1'b1;
    step();
    abort = 1'b0;
    outReady = 1'b1;
    check("abort_valid", 64'(outValid), 64'd0);
    check("abort_busy",  64'(busy),     64'd0);
    check("abort_done",  64'(done),     64'd0);
    seen = 0;
    for (int c = 0; c < 5; c++) begin
      if (outValid || done || busy) seen++;
      step();
    end
    check("abort_quiet", 64'(seen), 64'd0);
    runDump(0, 0, dc, dn, se, fv, r1);
    check("abort_restart_first", 64'(q.size() > 0 ? q[0] : 8'hFF), 64'd0);
    check("abort_restart_data",  64'(countMismatch()), 64'd0);
    check("abort_restart_bytes", 64'(q.size()), 64'd160);

    start = 1'b1; step(); start = 1'b0;
    hit = 0;
    for (int c = 0; c < 100; c++) begin
      if (outValid && dbgReg == 5'd3) begin
        hit = 1;
        break;
      end
      step();
    end
    check("rst_mid_reached", 64'(hit), 64'd1);
    rst = 1'b0;
    #1;
    check("rst_mid_valid", 64'(outValid), 64'd0);
    check("rst_mid_busy",  64'(busy),     64'd0);
    check("rst_mid_reg",   64'(dbgReg),   64'd0);
    check("rst_mid_data",  64'(outData),  64'd0);
    check("rst_mid_done",  64'(done),     64'd0);
    step(); step(); step();
    rst = 1'b1;
    step();
    runDump(0, 0, dc, dn, se, fv, r1);
    check("rst_after_bytes", 64'(q.size()), 64'd160);
    check("rst_after_data",  64'(countMismatch()), 64'd0);
    check("rst_after_done",  64'(dn), 64'd1);

    q2.delete();
    dn = 0;
    start2 = 1'b1; step(); step(); start2 = 1'b0;
    for (int c = 0; c < 40; c++) begin
      if (outValid2 && ready2) q2.push_back(outData2);
      if (done2) dn++;
      step();
    end
    check("sweep_bytes", 64'(q2.size()), 64'd4);
    check("sweep_word",  64'(q2.size() == 4 ? {q2[0], q2[1], q2[2], q2[3]} : 32'h0), 64'h1234_5678);
    check("sweep_done",  64'(dn), 64'd1);
    check("sweep_idle",  64'(busy2), 64'd0);

    $display("[TB] %0d tests run, %0d failed", nTests, nFail);
    $finish;
  end

endmodule
